watermark_embedder_core: RTL and testbench

WATERMARK_EMBEDDER_CORE -- requirements
Module: watermark_embedder_core

---
 rtl/watermark_embedder_core.sv | 166 ++++++++++++++++
 tb/tb_watermark_embedder_core.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/watermark_embedder_core.sv
// Embeds a gain-scaled 8-bit watermark into a rectangular window of a raster coefficient stream.
// Define WM_EMBED_SAT_EN to clamp overflowing sums; by default they wrap to COEF_W bits.
module watermark_embedder_core #(
   parameter int HOST_WIDTH  = 256,
   parameter int HOST_HEIGHT = 256,
   parameter int WM_WIDTH    = 128,
   parameter int WM_HEIGHT   = 128,
   parameter int ROW_OFF     = 64,
   parameter int COL_OFF     = 64,
   parameter int COEF_W      = 13,
   parameter int GAIN_NUM    = 3,
   parameter int GAIN_SHIFT  = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   input  logic signed [COEF_W-1:0] c_data,
   input  logic                     c_valid,
   output logic                     c_ready,
   input  logic        [7:0]        w_data,
   input  logic                     w_valid,
   output logic                     w_ready,
   output logic signed [COEF_W-1:0] o_data,
   output logic                     o_valid,
   input  logic                     o_ready
);

   // state | meaning
   // IDLE  | waiting for start, both inputs held off
   // RUN   | accepting the frame in raster order
   // DRAIN | last coefficient accepted, waiting for the output register to empty
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int ROW_W = $clog2(HOST_HEIGHT + 1);
   localparam int COL_W = $clog2(HOST_WIDTH + 1);
   localparam int RND   = 1 << (GAIN_SHIFT - 1);

   localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(HOST_HEIGHT - 1);
   localparam logic [COL_W-1:0] COL_LAST  = COL_W'(HOST_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(ROW_OFF);
   localparam logic [ROW_W-1:0] ROW_END   = ROW_W'(ROW_OFF + WM_HEIGHT);
   localparam logic [COL_W-1:0] COL_FIRST = COL_W'(COL_OFF);
   localparam logic [COL_W-1:0] COL_END   = COL_W'(COL_OFF + WM_WIDTH);

   localparam logic [COEF_W-1:0] COEF_MAX = {1'b0, {(COEF_W-1){1'b1}}};
   localparam logic [COEF_W-1:0] COEF_MIN = {1'b1, {(COEF_W-1){1'b0}}};

`ifdef WM_EMBED_SAT_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   generate
      if ((ROW_OFF + WM_HEIGHT > HOST_HEIGHT) || (COL_OFF + WM_WIDTH > HOST_WIDTH)) begin : g_window_check
         $error("watermark window does not fit inside the host frame");
      end
   endgenerate

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic [ROW_W-1:0]          r_row;
   logic [COL_W-1:0]          r_col;
   logic                      r_o_valid;
   logic signed [COEF_W-1:0]  r_o_data;

   logic                      w_in_win;
   logic                      w_last;
   logic                      w_free;
   logic                      w_c_xfer;
   logic [COEF_W:0]           w_wm_add;
   logic signed [COEF_W:0]    w_sum;
   logic                      w_ovf;
   logic signed [COEF_W-1:0]  w_result;

   assign w_in_win = (r_row >= ROW_FIRST) && (r_row < ROW_END) &&
                     (r_col >= COL_FIRST) && (r_col < COL_END);
   assign w_last   = (r_row == ROW_LAST) && (r_col == COL_LAST);
   assign w_free   = !r_o_valid || o_ready;
   assign w_c_xfer = c_valid && c_ready;

   // Rounded gain term; the sum keeps one guard bit so overflow is visible.
   assign w_wm_add = (COEF_W+1)'((32'(w_data) * 32'(GAIN_NUM) + 32'(RND)) >> GAIN_SHIFT);
   assign w_sum    = {c_data[COEF_W-1], c_data} + (w_in_win ? w_wm_add : '0);
   assign w_ovf    = w_sum[COEF_W] ^ w_sum[COEF_W-1];
   assign w_result = (SAT_EN && w_ovf) ? (w_sum[COEF_W] ? COEF_MIN : COEF_MAX)
                                       : w_sum[COEF_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      c_ready     = 1'b0;
      w_ready     = 1'b0;
      done        = 1'b0;
      busy        = (r_state != IDLE);
      case (r_state)
         IDLE: begin
            if (start) begin
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            c_ready = w_free && (!w_in_win || w_valid);
            w_ready = w_free && w_in_win && c_valid;
            if (c_valid && w_free && (!w_in_win || w_valid) && w_last) begin
               w_state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (!r_o_valid) begin
               w_state_nxt = IDLE;
               done        = 1'b1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_row <= '0;
         r_col <= '0;
      end else if ((r_state == IDLE) && start) begin
         r_row <= '0;
         r_col <= '0;
      end else if (w_c_xfer) begin
         if (r_col == COL_LAST) begin
            r_col <= '0;
            r_row <= (r_row == ROW_LAST) ? '0 : r_row + ROW_W'(1);
         end else begin
            r_col <= r_col + COL_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_o_valid <= 1'b0;
         r_o_data  <= '0;
      end else if (w_c_xfer) begin
         r_o_valid <= 1'b1;
         r_o_data  <= w_result;
      end else if (o_ready) begin
         r_o_valid <= 1'b0;
      end
   end

   assign o_valid = r_o_valid;
   assign o_data  = r_o_data;

endmodule

// File: tb/tb_watermark_embedder_core.sv
// Scoreboard bench for watermark_embedder_core on a reduced frame geometry with random handshakes.
// The reference model follows WM_EMBED_SAT_EN the same way the design does.
module tb_watermark_embedder_core;

   localparam int HW  = 20;
   localparam int HH  = 16;
   localparam int WMW = 8;
   localparam int WMH = 6;
   localparam int RO  = 4;
   localparam int CO  = 6;
   localparam int CW  = 13;
   localparam int GN  = 3;
   localparam int GS  = 8;
   localparam int N   = HW * HH;
   localparam int M   = WMW * WMH;
   localparam int WIN0 = RO * HW + CO;
   localparam int BUDGET = N * 20;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 start;
   logic                 busy;
   logic                 done;
   logic signed [CW-1:0] c_data;
   logic                 c_valid;
   logic                 c_ready;
   logic [7:0]           w_data;
   logic                 w_valid;
   logic                 w_ready;
   logic signed [CW-1:0] o_data;
   logic                 o_valid;
   logic                 o_ready;

   watermark_embedder_core #(
      .HOST_WIDTH(HW), .HOST_HEIGHT(HH), .WM_WIDTH(WMW), .WM_HEIGHT(WMH),
      .ROW_OFF(RO), .COL_OFF(CO), .COEF_W(CW), .GAIN_NUM(GN), .GAIN_SHIFT(GS)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
      .c_data(c_data), .c_valid(c_valid), .c_ready(c_ready),
      .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
      .o_data(o_data), .o_valid(o_valid), .o_ready(o_ready)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int sb[$];
   int coef[N];
   int wm[M];
   int o_prob  = 100;
   int done_cnt = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit in_win(input int k);
      int r = k / HW;
      int c = k % HW;
      return (r >= RO) && (r < RO + WMH) && (c >= CO) && (c < CO + WMW);
   endfunction

   // Embedded value from plain integer arithmetic on the frame position's rule.
   function automatic int model(input int c, input int w, input bit win);
      int s = c + (win ? (w * GN + (1 << (GS - 1))) / (1 << GS) : 0);
`ifdef WM_EMBED_SAT_EN
      if (s > (1 << (CW - 1)) - 1) s = (1 << (CW - 1)) - 1;
      if (s < -(1 << (CW - 1)))    s = -(1 << (CW - 1));
`else
      s = s % (1 << CW);
      if (s < 0) s += (1 << CW);
      if (s >= (1 << (CW - 1))) s -= (1 << CW);
`endif
      return s;
   endfunction

   always @(negedge clk) begin
      o_ready = ($urandom_range(0, 99) < o_prob);
      if (done) done_cnt++;
   end

   // Output monitor: pops the scoreboard on every output handshake and checks stall stability.
   initial begin
      bit held = 1'b0;
      int held_d = 0;
      int exp;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            held = 1'b0;
         end else begin
            if (held) begin
               chk("hold_valid", int'(o_valid), 1);
               chk("hold_data", int'(o_data), held_d);
            end
            held = 1'b0;
            if (o_valid && o_ready) begin
               if (sb.size() == 0) begin
                  chk("unexpected_output", int'(o_data), 32'h7fffffff);
               end else begin
                  exp = sb.pop_front();
                  chk("o_data", int'(o_data), exp);
               end
            end else if (o_valid) begin
               held   = 1'b1;
               held_d = int'(o_data);
            end
         end
      end
   end

   task automatic fill_frame();
      for (int i = 0; i < N; i++) coef[i] = int'($urandom_range(0, 8191)) - 4096;
      for (int i = 0; i < M; i++) wm[i] = int'($urandom_range(0, 255));
   endtask

   task automatic run_frame(input int c_prob, input int w_prob, input int abort_at,
                            input bit stall_win0, input int restart_cyc);
      int k = 0;
      int j = 0;
      int cyc = 0;
      int w_cnt = 0;
      int stall_left;
      int done_before;
      int t;
      bit win;
      bit acc;
      bit acc_last = 1'b0;
      bit wacc;
      done_before = done_cnt;
      stall_left  = stall_win0 ? 5 : 0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", int'(busy), 1);
      while (k < N && cyc < BUDGET) begin
         if (acc_last) chk("latency_o_valid", int'(o_valid), 1);
         if (k == abort_at) begin
            rst_n   = 1'b0;
            c_valid = 1'b0;
            w_valid = 1'b0;
            #1;
            chk("abort_busy", int'(busy), 0);
            chk("abort_o_valid", int'(o_valid), 0);
            chk("abort_o_data", int'(o_data), 0);
            chk("abort_c_ready", int'(c_ready), 0);
            chk("abort_w_ready", int'(w_ready), 0);
            sb.delete();
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            chk("abort_no_done", done_cnt, done_before);
            return;
         end
         win     = in_win(k);
         c_valid = ($urandom_range(0, 99) < c_prob);
         c_data  = CW'(coef[k]);
         w_valid = ($urandom_range(0, 99) < w_prob);
         w_data  = (j < M) ? 8'(wm[j]) : 8'($urandom_range(0, 255));
         start   = (cyc == restart_cyc);
         if (stall_left > 0 && win) begin
            c_valid = 1'b1;
            w_valid = 1'b0;
         end
         #1;
         if (stall_left > 0 && win) begin
            chk("stall_c_ready", int'(c_ready), 0);
            stall_left--;
         end
         if (!win) chk("w_ready_outside", int'(w_ready), 0);
         acc  = c_valid && c_ready;
         wacc = w_valid && w_ready;
         chk("paired_transfer", int'(wacc), int'(acc && win));
         if (wacc) w_cnt++;
         if (acc) begin
            sb.push_back(model(coef[k], win ? wm[j] : 0, win));
            k++;
            if (win) j++;
         end
         acc_last = acc;
         @(negedge clk);
         cyc++;
      end
      c_valid = 1'b0;
      w_valid = 1'b0;
      start   = 1'b0;
      chk("frame_accepted", k, N);
      chk("wm_consumed", w_cnt, M);
      t = 0;
      while (!done && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("done_seen", int'(done), 1);
      repeat (3) @(negedge clk);
      chk("busy_after_done", int'(busy), 0);
      chk("done_count", done_cnt - done_before, 1);
      chk("scoreboard_empty", sb.size(), 0);
   endtask

   initial begin
      rst_n   = 1'b0;
      start   = 1'b0;
      c_valid = 1'b0;
      c_data  = '0;
      w_valid = 1'b0;
      w_data  = '0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_o_valid", int'(o_valid), 0);
      chk("rst_o_data", int'(o_data), 0);
      chk("rst_c_ready", int'(c_ready), 0);
      chk("rst_w_ready", int'(w_ready), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_c_ready", int'(c_ready), 0);

      // Frame A: corner values plus a five-cycle watermark stall at the window's first pixel.
      fill_frame();
      coef[0]    = 100;
      coef[WIN0] = -20;
      wm[0]      = 200;
      o_prob     = 75;
      run_frame(80, 70, -1, 1'b1, -1);

      // Frame B: overflow at the window corner and at the opposite extreme.
      fill_frame();
      coef[WIN0]     = 4095;
      wm[0]          = 255;
      coef[WIN0 + 1] = -4096;
      wm[1]          = 0;
      o_prob         = 100;
      run_frame(100, 100, -1, 1'b0, -1);

      // Frame C is abandoned inside the window; frame D must start again at (0,0).
      fill_frame();
      o_prob = 60;
      run_frame(90, 90, (RO + 2) * HW + CO + 3, 1'b0, -1);
      fill_frame();
      o_prob = 70;
      run_frame(85, 85, -1, 1'b0, 40);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
